// File: rtl/squarer.sv
// Registered 3-bit unsigned squarer: bit-sliced operand in, bit-sliced 6-bit square out,
// one clock of latency, one result per clock.
module squarer (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic a2,
   input  logic a1,
   input  logic a0,
   output logic out_valid,
   output logic y5,
   output logic y4,
   output logic y3,
   output logic y2,
   output logic y1,
   output logic y0
);

   // Handshake: a2..a0 are taken on any rising edge with in_valid=1; out_valid
   // is high for exactly the following cycle. There is no ready, so the consumer
   // must take y5..y0 while out_valid=1 (the value is held afterwards but is stale).
   logic [5:0] sq;
   logic [5:0] y_q;
   logic       valid_q;

   always_comb begin
      sq    = 6'd0;
      sq[0] = a0;
      sq[1] = 1'b0;
      sq[2] = a1 & ~a0;
      sq[3] = a0 & (a1 ^ a2);
      sq[4] = a2 & (~a1 | a0);
      sq[5] = a2 & a1;
   end

   // The operand only reaches the result register through the enable, so
   // unknown operand bits while in_valid=0 cannot leak into the held value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= 6'd0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            y_q <= sq;
         end
      end
   end

   assign out_valid = valid_q;
   assign y5        = y_q[5];
   assign y4        = y_q[4];
   assign y3        = y_q[3];
   assign y2        = y_q[2];
   assign y1        = y_q[1];
   assign y0        = y_q[0];

endmodule

// File: tb/tb_squarer.sv
// Directed bench for squarer: reset, exhaustive sweep, hold, async reset and
// back-to-back throughput, all against hand-computed squares.
module tb_squarer;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic a2, a1, a0;
   logic out_valid;
   logic y5, y4, y3, y2, y1, y0;
   logic [5:0] y;

   int n_checks;
   int n_pass;

   logic [5:0] exp_q[$];
   logic [5:0] sq_tab [8];

   squarer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a2        (a2),
      .a1        (a1),
      .a0        (a0),
      .out_valid (out_valid),
      .y5        (y5),
      .y4        (y4),
      .y3        (y3),
      .y2        (y2),
      .y1        (y1),
      .y0        (y0)
   );

   assign y = {y5, y4, y3, y2, y1, y0};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (%b) expected %0d (%b)", tag, got, got, exp, exp);
      end
   endtask

   // driver: present inputs, then move to 1 time unit after the capturing edge
   task automatic step(input logic v, input logic [2:0] a);
      in_valid = v;
      {a2, a1, a0} = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] e;
      sq_tab = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
      n_checks = 0;
      n_pass   = 0;
      in_valid = 1'b0;
      {a2, a1, a0} = 3'd0;
      rst_n = 1'b0;

      // reset state
      #3;
      check("reset_y", y, 6'd0);
      check("reset_valid", {5'd0, out_valid}, 6'd1 - 6'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 3'd0);
      check("idle_y", y, 6'd0);
      check("idle_valid", {5'd0, out_valid}, 6'd0);

      // exhaustive sweep with a scoreboard queue
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(sq_tab[i]);
         step(1'b1, 3'(i));
         e = exp_q.pop_front();
         check($sformatf("sweep_y_a%0d", i), y, e);
         check($sformatf("sweep_valid_a%0d", i), {5'd0, out_valid}, 6'd1);
         check($sformatf("sweep_y1_a%0d", i), {5'd0, y1}, 6'd0);
      end

      // boundaries with explicit bit patterns
      step(1'b1, 3'd7);
      check("bound_a7", y, 6'b110001);
      step(1'b1, 3'd6);
      check("bound_a6", y, 6'b100100);
      step(1'b1, 3'd0);
      check("bound_a0", y, 6'b000000);

      // hold when not valid, including unknown operand bits
      step(1'b1, 3'd5);
      check("hold_load", y, 6'd25);
      step(1'b0, 3'd7);
      check("hold_y", y, 6'd25);
      check("hold_valid", {5'd0, out_valid}, 6'd0);
      step(1'b0, 3'bxxx);
      check("hold_x_y", y, 6'd25);
      check("hold_x_valid", {5'd0, out_valid}, 6'd0);

      // asynchronous reset mid-cycle with nonzero outputs
      step(1'b1, 3'd7);
      check("pre_rst_y", y, 6'd49);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_y", y, 6'd0);
      check("async_rst_valid", {5'd0, out_valid}, 6'd0);
      rst_n = 1'b1;
      step(1'b0, 3'd0);
      check("post_rst_idle_y", y, 6'd0);

      // valid A=3 in flight, reset before the capturing edge
      in_valid = 1'b1;
      {a2, a1, a0} = 3'd3;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("inflight_y", y, 6'd0);
      check("inflight_valid", {5'd0, out_valid}, 6'd0);
      #2;
      rst_n = 1'b1;
      step(1'b1, 3'd3);
      check("after_rst_y", y, 6'd9);
      check("after_rst_valid", {5'd0, out_valid}, 6'd1);

      // throughput: alternate 7 and 1 back to back
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back((i % 2 == 0) ? 6'd49 : 6'd1);
         step(1'b1, (i % 2 == 0) ? 3'd7 : 3'd1);
         e = exp_q.pop_front();
         check($sformatf("tput_y_%0d", i), y, e);
         check($sformatf("tput_valid_%0d", i), {5'd0, out_valid}, 6'd1);
      end
      step(1'b0, 3'd2);
      check("tput_end_valid", {5'd0, out_valid}, 6'd0);
      check("tput_end_y", y, 6'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
